// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcodes, FSM state
// encodings, ALU function codes, the control-word layout and the ALU-class
// opcode decoder used by both the next-state logic and the output decode.
package cpu_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // FSM state encodings (visible on the State debug port)
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // PC source and destination-register selects
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;
  localparam logic [1:0] RD_RA     = 2'b00;
  localparam logic [1:0] RD_RT     = 2'b01;
  localparam logic [1:0] RD_RD     = 2'b10;

  // Full set of datapath controls produced each cycle
  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic       ins_mem_rw;
    logic       m_rd;
    logic       m_wr;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic       wr_reg_d_src;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  // Datapath setup for the register/immediate ALU instruction class
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic       src_a;
    logic       src_b;
    logic       ext;
    logic [1:0] reg_dst;
  } alu_decode_t;

  // Classify an opcode as an ALU instruction and return its datapath setup.
  // Logical immediates zero-extend; arithmetic immediates sign-extend.
  function automatic alu_decode_t alu_decode(input logic [5:0] op);
    alu_decode_t d;
    case (op)
      OP_ADD:   d = '{1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, RD_RD};
      OP_SUB:   d = '{1'b1, ALU_SUB, 1'b0, 1'b0, 1'b0, RD_RD};
      OP_ADDIU: d = '{1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1, RD_RT};
      OP_AND:   d = '{1'b1, ALU_AND, 1'b0, 1'b0, 1'b0, RD_RD};
      OP_ANDI:  d = '{1'b1, ALU_AND, 1'b0, 1'b1, 1'b0, RD_RT};
      OP_ORI:   d = '{1'b1, ALU_OR,  1'b0, 1'b1, 1'b0, RD_RT};
      OP_SLL:   d = '{1'b1, ALU_SLL, 1'b1, 1'b0, 1'b0, RD_RD};
      OP_SLTI:  d = '{1'b1, ALU_SLT, 1'b0, 1'b1, 1'b1, RD_RT};
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_decode.sv
// ctrl_decode: combinational mapping of {state, opcode, Zero} to the datapath
// control word. Build option MEM_WAIT_EN adds the MemReady input so that a
// store only writes the PC on the cycle the memory accepts it.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic [5:0]        opcode_i,
  input  logic              zero_i,
`ifdef MEM_WAIT_EN
  input  logic              mem_ready_i,
`endif
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_word_t  ctrl_s;
  alu_decode_t alu_s;
  logic        br_taken_s;
  logic        sw_pc_wre_s;

  assign alu_s      = alu_decode(opcode_i);
  assign br_taken_s = ((opcode_i == OP_BEQ) &&  zero_i) ||
                      ((opcode_i == OP_BNE) && !zero_i);
`ifdef MEM_WAIT_EN
  assign sw_pc_wre_s = mem_ready_i;
`else
  assign sw_pc_wre_s = 1'b1;
`endif
  assign ctrl_o = ctrl_s;

  // Moore decode of the current state; only branch PCSrc looks at Zero
  always_comb begin
    ctrl_s = '0;
    case (state_i)
      S_IF: begin
        ctrl_s.ir_wre     = 1'b1;
        ctrl_s.ins_mem_rw = 1'b1;
      end
      S_ID: begin
        case (opcode_i)
          OP_J: begin
            ctrl_s.pc_wre = 1'b1;
            ctrl_s.pc_src = PC_JUMP;
          end
          OP_JAL: begin
            ctrl_s.pc_wre       = 1'b1;
            ctrl_s.pc_src       = PC_JUMP;
            ctrl_s.reg_wre      = 1'b1;
            ctrl_s.reg_dst      = RD_RA;
            ctrl_s.wr_reg_d_src = 1'b0;
          end
          OP_JR: begin
            ctrl_s.pc_wre = 1'b1;
            ctrl_s.pc_src = PC_JR;
          end
          OP_HALT, OP_BEQ, OP_BNE, OP_LW, OP_SW: begin
            ctrl_s.pc_wre = 1'b0;
          end
          default: begin
            // ALU instructions continue; anything unrecognised retires as a NOP
            ctrl_s.pc_wre = !alu_s.valid;
          end
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        ctrl_s.alu_op    = alu_s.alu_op;
        ctrl_s.alu_src_a = alu_s.src_a;
        ctrl_s.alu_src_b = alu_s.src_b;
        ctrl_s.ext_sel   = alu_s.ext;
        if (state_i == S_WB_AL) begin
          ctrl_s.reg_wre      = 1'b1;
          ctrl_s.pc_wre       = 1'b1;
          ctrl_s.wr_reg_d_src = 1'b1;
          ctrl_s.reg_dst      = alu_s.reg_dst;
        end else begin
          ctrl_s.reg_wre = 1'b0;
        end
      end
      S_EXE_BR: begin
        ctrl_s.alu_op  = ALU_SUB;
        ctrl_s.ext_sel = 1'b1;
        ctrl_s.pc_wre  = 1'b1;
        ctrl_s.pc_src  = br_taken_s ? PC_BRANCH : PC_NEXT;
      end
      S_EXE_LS, S_MEM: begin
        // address computation is held stable through the memory access
        ctrl_s.alu_src_b = 1'b1;
        ctrl_s.ext_sel   = 1'b1;
        ctrl_s.alu_op    = ALU_ADD;
        if (state_i == S_MEM) begin
          if (opcode_i == OP_SW) begin
            ctrl_s.m_wr   = 1'b1;
            ctrl_s.pc_wre = sw_pc_wre_s;
          end else begin
            ctrl_s.m_rd = 1'b1;
          end
        end else begin
          ctrl_s.m_rd = 1'b0;
        end
      end
      S_WB_LD: begin
        ctrl_s.db_data_src  = 1'b1;
        ctrl_s.wr_reg_d_src = 1'b1;
        ctrl_s.reg_dst      = RD_RT;
        ctrl_s.reg_wre      = 1'b1;
        ctrl_s.pc_wre       = 1'b1;
      end
      S_HALT: begin
        ctrl_s = '0;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: instruction sequencer for the multi-cycle CPU
// (IF/ID/EXE/MEM/WB). Holds the state register and next-state logic; all
// datapath controls come from ctrl_decode. Optional build macro MEM_WAIT_EN
// makes sMEM wait for MemReady; without it MemReady is ignored.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int OPCODE_W = 6
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic                InsMemRW,
  output logic                mRD,
  output logic                mWR,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic                WrRegDSrc,
  output logic                ExtSel,
  output logic [1:0]          PCSrc,
  output logic [1:0]          RegDst,
  output logic [2:0]          ALUOp,
  output logic [STATE_W-1:0]  State
);

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  opcode_s;
  alu_decode_t alu_s;
  ctrl_word_t  ctrl_s;

  assign opcode_s = 6'(Opcode);
  assign alu_s    = alu_decode(opcode_s);

`ifndef MEM_WAIT_EN
  logic mem_ready_unused_s;
  assign mem_ready_unused_s = MemReady;
`endif

  ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_s),
    .zero_i      (Zero),
`ifdef MEM_WAIT_EN
    .mem_ready_i (MemReady),
`endif
    .ctrl_o      (ctrl_s)
  );

  // Next-state selection from current state and opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (alu_s.valid) begin
          state_d = S_EXE_AL;
        end else begin
          case (opcode_s)
            OP_J, OP_JAL, OP_JR: state_d = S_IF;
            OP_HALT:             state_d = S_HALT;
            OP_BEQ, OP_BNE:      state_d = S_EXE_BR;
            OP_LW, OP_SW:        state_d = S_EXE_LS;
            default:             state_d = S_IF;
          endcase
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
`ifdef MEM_WAIT_EN
        if (!MemReady) begin
          state_d = S_MEM;
        end else if (opcode_s == OP_SW) begin
          state_d = S_IF;
        end else begin
          state_d = S_WB_LD;
        end
`else
        if (opcode_s == OP_SW) begin
          state_d = S_IF;
        end else begin
          state_d = S_WB_LD;
        end
`endif
      end
      S_WB_LD: state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // State register; active-low reset wins over every other input
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  assign PCWre     = ctrl_s.pc_wre;
  assign IRWre     = ctrl_s.ir_wre;
  assign RegWre    = ctrl_s.reg_wre;
  assign InsMemRW  = ctrl_s.ins_mem_rw;
  assign mRD       = ctrl_s.m_rd;
  assign mWR       = ctrl_s.m_wr;
  assign ALUSrcA   = ctrl_s.alu_src_a;
  assign ALUSrcB   = ctrl_s.alu_src_b;
  assign DBDataSrc = ctrl_s.db_data_src;
  assign WrRegDSrc = ctrl_s.wr_reg_d_src;
  assign ExtSel    = ctrl_s.ext_sel;
  assign PCSrc     = ctrl_s.pc_src;
  assign RegDst    = ctrl_s.reg_dst;
  assign ALUOp     = ctrl_s.alu_op;
  assign State     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each instruction pushes its
// expected per-cycle control words onto a scoreboard queue; the queue is then
// drained one entry per clock and compared with the DUT on the falling edge.
// Build with +define+MEM_WAIT_EN to exercise the memory-wait variant.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OPC_ADD   = 6'b000000;
  localparam logic [5:0] OPC_SUB   = 6'b000001;
  localparam logic [5:0] OPC_ADDIU = 6'b000010;
  localparam logic [5:0] OPC_AND   = 6'b010000;
  localparam logic [5:0] OPC_ANDI  = 6'b010001;
  localparam logic [5:0] OPC_ORI   = 6'b010010;
  localparam logic [5:0] OPC_SLL   = 6'b011000;
  localparam logic [5:0] OPC_SLTI  = 6'b100111;
  localparam logic [5:0] OPC_SW    = 6'b110000;
  localparam logic [5:0] OPC_LW    = 6'b110001;
  localparam logic [5:0] OPC_BEQ   = 6'b110100;
  localparam logic [5:0] OPC_BNE   = 6'b110101;
  localparam logic [5:0] OPC_J     = 6'b111000;
  localparam logic [5:0] OPC_JR    = 6'b111001;
  localparam logic [5:0] OPC_JAL   = 6'b111010;
  localparam logic [5:0] OPC_HALT  = 6'b111111;
  localparam logic [5:0] OPC_UNDEF = 6'b101010;

  localparam logic [3:0] ST_IF   = 4'b0000;
  localparam logic [3:0] ST_ID   = 4'b0001;
  localparam logic [3:0] ST_LS   = 4'b0010;
  localparam logic [3:0] ST_MEM  = 4'b0011;
  localparam logic [3:0] ST_WBLD = 4'b0100;
  localparam logic [3:0] ST_BR   = 4'b0101;
  localparam logic [3:0] ST_AL   = 4'b0110;
  localparam logic [3:0] ST_WBAL = 4'b0111;
  localparam logic [3:0] ST_HALT = 4'b1000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rgw, imr, mrd, mwr, sa, sb, dbs, wrs, ext;
    logic [1:0] pcs;
    logic [1:0] rdst;
    logic [2:0] aop;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic mr;
  } stim_t;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWre, IRWre, RegWre, InsMemRW, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] State;

  stim_t sq[$];
  int    checks = 0;
  int    errors = 0;
`ifdef MEM_WAIT_EN
  logic  mr_exit = 1'b1;
`else
  logic  mr_exit = 1'b0;
`endif

  multicycle_ctrl_fsm dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .InsMemRW(InsMemRW),
    .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp), .State(State)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t obs_now();
    exp_t o;
    o.st = State;      o.pcw = PCWre;     o.irw = IRWre;    o.rgw = RegWre;
    o.imr = InsMemRW;  o.mrd = mRD;       o.mwr = mWR;      o.sa = ALUSrcA;
    o.sb = ALUSrcB;    o.dbs = DBDataSrc; o.wrs = WrRegDSrc; o.ext = ExtSel;
    o.pcs = PCSrc;     o.rdst = RegDst;   o.aop = ALUOp;
    return o;
  endfunction

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t if_word();
    exp_t e;
    e = base(ST_IF);
    e.irw = 1'b1;
    e.imr = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input logic mr);
    stim_t s;
    s.e = e;
    s.mr = mr;
    sq.push_back(s);
  endtask

  // Expected cycle-by-cycle sequence for one instruction
  task automatic build(input logic [5:0] op, input logic z, input int nwait);
    exp_t e;
    logic [2:0] aop;
    logic sa, sb, ext;
    logic [1:0] rd;
    push(if_word(), 1'b0);
    e = base(ST_ID);
    case (op)
      OPC_J:   begin e.pcw = 1'b1; e.pcs = 2'b11; push(e, 1'b0); end
      OPC_JR:  begin e.pcw = 1'b1; e.pcs = 2'b10; push(e, 1'b0); end
      OPC_JAL: begin e.pcw = 1'b1; e.pcs = 2'b11; e.rgw = 1'b1; push(e, 1'b0); end
      OPC_HALT: begin
        push(e, 1'b0);
        for (int i = 0; i < 20; i++) push(base(ST_HALT), 1'b0);
      end
      OPC_BEQ, OPC_BNE: begin
        push(e, 1'b0);
        e = base(ST_BR);
        e.aop = 3'd1; e.ext = 1'b1; e.pcw = 1'b1;
        e.pcs = (((op == OPC_BEQ) && z) || ((op == OPC_BNE) && !z)) ? 2'b01 : 2'b00;
        push(e, 1'b0);
      end
      OPC_LW, OPC_SW: begin
        push(e, 1'b0);
        e = base(ST_LS);
        e.sb = 1'b1; e.ext = 1'b1; e.aop = 3'd0;
        push(e, 1'b0);
        e.st = ST_MEM;
        if (op == OPC_SW) e.mwr = 1'b1; else e.mrd = 1'b1;
        for (int i = 0; i < nwait; i++) push(e, 1'b0);
        if (op == OPC_SW) e.pcw = 1'b1; else e.pcw = 1'b0;
        push(e, mr_exit);
        if (op == OPC_LW) begin
          e = base(ST_WBLD);
          e.dbs = 1'b1; e.wrs = 1'b1; e.rdst = 2'b01; e.rgw = 1'b1; e.pcw = 1'b1;
          push(e, 1'b0);
        end
      end
      OPC_ADD, OPC_SUB, OPC_ADDIU, OPC_AND, OPC_ANDI, OPC_ORI, OPC_SLL, OPC_SLTI: begin
        push(e, 1'b0);
        case (op)
          OPC_ADD:   {aop, sa, sb, ext, rd} = {3'd0, 1'b0, 1'b0, 1'b0, 2'b10};
          OPC_SUB:   {aop, sa, sb, ext, rd} = {3'd1, 1'b0, 1'b0, 1'b0, 2'b10};
          OPC_ADDIU: {aop, sa, sb, ext, rd} = {3'd0, 1'b0, 1'b1, 1'b1, 2'b01};
          OPC_AND:   {aop, sa, sb, ext, rd} = {3'd2, 1'b0, 1'b0, 1'b0, 2'b10};
          OPC_ANDI:  {aop, sa, sb, ext, rd} = {3'd2, 1'b0, 1'b1, 1'b0, 2'b01};
          OPC_ORI:   {aop, sa, sb, ext, rd} = {3'd3, 1'b0, 1'b1, 1'b0, 2'b01};
          OPC_SLL:   {aop, sa, sb, ext, rd} = {3'd4, 1'b1, 1'b0, 1'b0, 2'b10};
          default:   {aop, sa, sb, ext, rd} = {3'd5, 1'b0, 1'b1, 1'b1, 2'b01};
        endcase
        e = base(ST_AL);
        e.aop = aop; e.sa = sa; e.sb = sb; e.ext = ext;
        push(e, 1'b0);
        e.st = ST_WBAL; e.rgw = 1'b1; e.pcw = 1'b1; e.wrs = 1'b1; e.rdst = rd;
        push(e, 1'b0);
      end
      default: begin e.pcw = 1'b1; push(e, 1'b0); end
    endcase
  endtask

  // Drive one instruction and drain its scoreboard entries; rst_at >= 0 stops
  // after that cycle's comparison so that a reset can be applied mid-instruction
  task automatic run(input string tag, input logic [5:0] op, input logic z,
                     input int nwait, input int rst_at);
    int pcw_cnt;
    int idx;
    stim_t s;
    pcw_cnt = 0;
    idx = 0;
    Opcode = op;
    Zero = z;
    build(op, z, nwait);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      MemReady = s.mr;
      @(negedge CLK);
      check_eq($sformatf("%s_c%0d", tag, idx), 32'(obs_now()), 32'(s.e));
      pcw_cnt += int'(PCWre);
      if (idx == rst_at) begin
        sq.delete();
      end else begin
        @(posedge CLK);
        #1;
      end
      idx++;
    end
    if (rst_at < 0) begin
      check_eq({tag, "_pcw_cnt"}, 32'(pcw_cnt), (op == OPC_HALT) ? 32'd0 : 32'd1);
    end
  endtask

  // Hold reset low for n edges with hostile inputs; each edge must land in IF
  task automatic apply_reset(input int n);
    Reset = 1'b0;
    Opcode = OPC_SW;
    Zero = 1'b1;
    MemReady = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
      check_eq("rst", 32'(obs_now()), 32'(if_word()));
    end
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    Opcode = OPC_ADD;
    Zero = 1'b0;
    MemReady = 1'b0;
    apply_reset(2);
    run("add",    OPC_ADD,   1'b1, 0, -1);
    run("sub",    OPC_SUB,   1'b0, 0, -1);
    run("addiu",  OPC_ADDIU, 1'b1, 0, -1);
    run("and",    OPC_AND,   1'b0, 0, -1);
    run("andi",   OPC_ANDI,  1'b1, 0, -1);
    run("ori",    OPC_ORI,   1'b0, 0, -1);
    run("sll",    OPC_SLL,   1'b1, 0, -1);
    run("slti",   OPC_SLTI,  1'b0, 0, -1);
    run("beq_z1", OPC_BEQ,   1'b1, 0, -1);
    run("beq_z0", OPC_BEQ,   1'b0, 0, -1);
    run("bne_z0", OPC_BNE,   1'b0, 0, -1);
    run("bne_z1", OPC_BNE,   1'b1, 0, -1);
    run("lw",     OPC_LW,    1'b0, 0, -1);
    run("sw",     OPC_SW,    1'b1, 0, -1);
    run("jal",    OPC_JAL,   1'b0, 0, -1);
    run("j",      OPC_J,     1'b1, 0, -1);
    run("jr",     OPC_JR,    1'b0, 0, -1);
    run("nop",    OPC_UNDEF, 1'b1, 0, -1);
`ifdef MEM_WAIT_EN
    run("sw_wait", OPC_SW,   1'b0, 3, -1);
    run("lw_wait", OPC_LW,   1'b1, 1, -1);
`endif
    run("rst_wb", OPC_ADD,   1'b0, 0, 3);
    apply_reset(2);
    run("add_rst", OPC_ADD,  1'b0, 0, -1);
    run("halt",   OPC_HALT,  1'b0, 0, -1);
    apply_reset(1);
    run("add_end", OPC_ADD,  1'b1, 0, -1);
    @(negedge CLK);
    check_eq("end_if", 32'(State), 32'(ST_IF));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
